// File: rtl/pemstat_rxseq.sv
// Receive-statistics sequencer: buffers per-frame status vectors and serialises them into counter updates.
// Optional size-bin updates are built when PEMSTAT_RXSEQ_SIZEBIN_EN is defined.
module pemstat_rxseq #(
    parameter int DLY        = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sv_valid,
    input  logic [15:0] sv_len,
    input  logic [5:0]  sv_flags,
    input  logic        stat_hold,
    input  logic        stat_clr,
    output logic        inc_en,
    output logic [3:0]  inc_sel,
    output logic [15:0] inc_val,
    output logic        drop_pulse,
    output logic [7:0]  drop_cnt,
    output logic        busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    generate
        if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || DLY < 0) begin : g_bad_param
            $error("pemstat_rxseq: FIFO_DEPTH must be a power of 2 in 2..16");
        end
    endgenerate

`ifdef PEMSTAT_RXSEQ_SIZEBIN_EN
    typedef enum logic [2:0] {S_IDLE, S_BYTES, S_FRAMES, S_FLAGS, S_BIN} state_t;

    // 64 exactly is its own bin; everything above 1023 shares the last one.
    function automatic logic [2:0] size_bin(input logic [15:0] len);
        if (|len[15:10])  return 3'd5;
        else if (len[9])  return 3'd4;
        else if (len[8])  return 3'd3;
        else if (len[7])  return 3'd2;
        else              return (len[5:0] == 6'd0) ? 3'd0 : 3'd1;
    endfunction
`else
    typedef enum logic [2:0] {S_IDLE, S_BYTES, S_FRAMES, S_FLAGS} state_t;
`endif

    logic [21:0]    mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]  count_reg, count_next;
    state_t         state_reg, state_next;
    logic [15:0]    len_reg, len_next;
    logic [5:0]     pend_reg, pend_next;
    logic           fifo_full, push, drop, pop, seq_done, to_tail;
    logic           issue_en;
    logic [3:0]     issue_sel;
    logic [15:0]    issue_val;
    logic [2:0]     flag_idx;

    assign fifo_full  = (count_reg == DEPTH_C);
    assign push       = sv_valid && !fifo_full;
    assign drop       = sv_valid && fifo_full;
    assign count_next = count_reg + CW'(push) - CW'(pop);

    always_comb begin
        flag_idx = 3'd0;
        for (int i = 5; i >= 0; i--)
            if (pend_reg[i]) flag_idx = 3'(i);
    end

    always_comb begin
        state_next = state_reg;
        len_next   = len_reg;
        pend_next  = pend_reg;
        pop        = 1'b0;
        seq_done   = 1'b0;
        to_tail    = 1'b0;
        issue_en   = 1'b0;
        issue_sel  = inc_sel;
        issue_val  = 16'd0;
        case (state_reg)
            S_IDLE: seq_done = 1'b1;
            S_BYTES: begin
                issue_en   = 1'b1;
                issue_sel  = 4'd0;
                issue_val  = len_reg;
                state_next = S_FRAMES;
            end
            S_FRAMES: begin
                issue_en  = 1'b1;
                issue_sel = 4'd1;
                issue_val = 16'd1;
                if (|pend_reg) state_next = S_FLAGS;
                else           to_tail    = 1'b1;
            end
            S_FLAGS: begin
                issue_en  = 1'b1;
                issue_sel = 4'd2 + {1'b0, flag_idx};
                issue_val = 16'd1;
                pend_next = pend_reg & (pend_reg - 6'd1);
                if (pend_next == 6'd0) to_tail = 1'b1;
            end
`ifdef PEMSTAT_RXSEQ_SIZEBIN_EN
            S_BIN: begin
                issue_en  = 1'b1;
                issue_sel = 4'd8 + {1'b0, size_bin(len_reg)};
                issue_val = 16'd1;
                seq_done  = 1'b1;
            end
`endif
            default: state_next = S_IDLE;
        endcase

        if (to_tail) begin
`ifdef PEMSTAT_RXSEQ_SIZEBIN_EN
            if (|len_reg[15:6]) state_next = S_BIN;
            else                seq_done   = 1'b1;
`else
            seq_done = 1'b1;
`endif
        end

        // Chain straight into the next queued vector so bursts sequence without idle gaps.
        if (seq_done) begin
            if (count_reg != '0) begin
                pop        = 1'b1;
                len_next   = mem[rd_ptr_reg][15:0];
                pend_next  = mem[rd_ptr_reg][21:16];
                state_next = S_BYTES;
            end else begin
                state_next = S_IDLE;
            end
        end

        if (stat_hold) begin
            state_next = state_reg;
            len_next   = len_reg;
            pend_next  = pend_reg;
            pop        = 1'b0;
            issue_en   = 1'b0;
            issue_sel  = inc_sel;
            issue_val  = 16'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !stat_clr) mem[wr_ptr_reg] <= {sv_flags, sv_len};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= S_IDLE;
            len_reg    <= 16'd0;
            pend_reg   <= 6'd0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            inc_en     <= 1'b0;
            inc_sel    <= 4'd0;
            inc_val    <= 16'd0;
            drop_pulse <= 1'b0;
            drop_cnt   <= 8'd0;
            busy       <= 1'b0;
        end else if (stat_clr) begin
            state_reg  <= S_IDLE;
            pend_reg   <= 6'd0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            inc_en     <= 1'b0;
            inc_val    <= 16'd0;
            drop_pulse <= 1'b0;
            drop_cnt   <= 8'd0;
            busy       <= 1'b0;
        end else begin
            state_reg  <= state_next;
            len_reg    <= len_next;
            pend_reg   <= pend_next;
            count_reg  <= count_next;
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            inc_en     <= issue_en;
            inc_sel    <= issue_sel;
            inc_val    <= issue_val;
            drop_pulse <= drop;
            if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
            busy       <= (count_next != '0) || (state_next != S_IDLE);
        end
    end

endmodule
